// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, prefix-state enum and helpers for the PS/2 keyboard decoder
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT    = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK    = 8'hF0;
   localparam logic [7:0] PS2_PFX_E1     = 8'hE1;
   localparam int         PS2_FRAME_BITS = 11;

   typedef enum logic [1:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK
   } ps2_pfx_t;

   function automatic logic ps2_is_prefix(input logic [7:0] code);
      return (code == PS2_PFX_EXT) || (code == PS2_PFX_BRK) || (code == PS2_PFX_E1);
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin synchroniser, clock filter and 11-bit frame receiver with timeout
module ps2_rx_frame
   import ps2_pkg::*;
#(
   parameter int          FILTER_LEN = 8,
   parameter logic [23:0] TIMEOUT    = 24'd2_000_000
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] data_byte,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [3:0] LAST_BIT = 4'(PS2_FRAME_BITS - 1);
   localparam logic [3:0] PAR_BIT  = 4'(PS2_FRAME_BITS - 2);

   logic [1:0]    clk_sync;
   logic [1:0]    data_sync;
   logic          filt_clk;
   logic          filt_prev;
   logic [FW-1:0] filt_cnt;
   logic [3:0]    bitcnt;
   logic [7:0]    shreg;
   logic          parity_acc;
   logic [23:0]   tcnt;
   logic          fall;
   logic          sdata;
   logic          timeout_hit;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
         filt_cnt  <= '0;
      end else begin
         filt_prev <= filt_clk;
         if (clk_sync[1] == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_sync[1];
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall        = filt_prev & ~filt_clk;
   assign sdata       = data_sync[1];
   assign timeout_hit = (bitcnt != 4'd0) && !fall && (tcnt == TIMEOUT - 24'd1);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bitcnt     <= 4'd0;
         shreg      <= 8'h00;
         parity_acc <= 1'b0;
         byte_valid <= 1'b0;
         data_byte  <= 8'h00;
         frame_err  <= 1'b0;
         tcnt       <= 24'd0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (bitcnt == 4'd0 || fall || timeout_hit) begin
            tcnt <= 24'd0;
         end else begin
            tcnt <= tcnt + 24'd1;
         end

         if (fall) begin
            if (bitcnt == 4'd0) begin
               // A high start bit is rejected on the spot so the receiver realigns.
               if (sdata) begin
                  frame_err <= 1'b1;
               end else begin
                  bitcnt     <= 4'd1;
                  parity_acc <= 1'b0;
               end
            end else if (bitcnt < PAR_BIT) begin
               shreg      <= {sdata, shreg[7:1]};
               parity_acc <= parity_acc ^ sdata;
               bitcnt     <= bitcnt + 4'd1;
            end else if (bitcnt == PAR_BIT) begin
               parity_acc <= parity_acc ^ sdata;
               bitcnt     <= LAST_BIT;
            end else begin
               bitcnt <= 4'd0;
               if (parity_acc && sdata) begin
                  byte_valid <= 1'b1;
                  data_byte  <= shreg;
               end else begin
                  frame_err <= 1'b1;
               end
            end
         end else if (timeout_hit) begin
            bitcnt    <= 4'd0;
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard front end folding E0/F0 prefixes into toggling ps2_key events
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int          FILTER_LEN = 8,
   parameter logic [23:0] TIMEOUT    = 24'd2_000_000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err
);

   logic       byte_valid;
   logic [7:0] rx_byte;
   ps2_pfx_t   state;
   ps2_pfx_t   state_nxt;
   logic       emit;
   logic [9:0] event_word;

   ps2_rx_frame #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_rx (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .data_byte  (rx_byte),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (byte_valid) begin
         if (rx_byte == PS2_PFX_EXT) begin
            if (state == IDLE) begin
               state_nxt = EXT;
            end else if (state == BRK) begin
               state_nxt = EXT_BRK;
            end
         end else if (rx_byte == PS2_PFX_BRK) begin
            if (state == IDLE) begin
               state_nxt = BRK;
            end else if (state == EXT) begin
               state_nxt = EXT_BRK;
            end
         end else if (rx_byte != PS2_PFX_E1) begin
            state_nxt = IDLE;
         end
      end
   end

   always_comb begin
      emit       = byte_valid && !ps2_is_prefix(rx_byte);
      event_word = {~(state == BRK || state == EXT_BRK),
                    (state == EXT || state == EXT_BRK),
                    rx_byte};
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         ps2_key <= 11'h000;
      end else if (emit) begin
         ps2_key <= {~ps2_key[10], event_word};
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
module tb_ps2_key_decoder;

   localparam int          FILTER_LEN = 8;
   localparam logic [23:0] TIMEOUT    = 24'd400;
   localparam int          HALF       = 20;
   localparam logic [11:0] ERR_TOKEN  = 12'h800;
   localparam logic [11:0] NONE       = 12'hFFF;

   logic        clk_sys = 1'b0;
   logic        reset   = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        frame_err;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          stop_cyc = 0;
   bit          lat_armed = 1'b0;
   logic        prev_tgl  = 1'b0;
   int          err_len   = 0;
   logic [11:0] exp_q[$];

   ps2_key_decoder #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .ps2_key   (ps2_key),
      .frame_err (frame_err)
   );

   always #5 clk_sys = ~clk_sys;
   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      logic [11:0] e;
      if (reset) begin
         prev_tgl = ps2_key[10];
         err_len  = 0;
      end else begin
         if (ps2_key[10] != prev_tgl) begin
            prev_tgl = ps2_key[10];
            e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
            check_eq("key_event", {22'd0, ps2_key[9:0]}, {20'd0, e});
            if (lat_armed) begin
               lat_armed = 1'b0;
               check_eq("latency", cyc - stop_cyc, FILTER_LEN + 4);
            end
         end
         if (frame_err) begin
            err_len++;
            if (err_len == 1) begin
               e = (exp_q.size() != 0) ? exp_q.pop_front() : NONE;
               check_eq("frame_err_event", {20'd0, ERR_TOKEN}, {20'd0, e});
            end
         end else if (err_len != 0) begin
            check_eq("frame_err_width", err_len, 1);
            err_len = 0;
         end
      end
   end

   task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits);
      logic [10:0] bits;
      bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(posedge clk_sys); #1;
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk_sys);
         #1;
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         repeat (HALF) @(posedge clk_sys);
         #1;
         ps2_clk = 1'b1;
      end
      @(posedge clk_sys); #1;
      ps2_data = 1'b1;
      repeat (3 * HALF) @(posedge clk_sys);
   endtask

   task automatic drain(input string tag, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk_sys);
      repeat (4) @(posedge clk_sys);
      check_eq(tag, exp_q.size(), 0);
   endtask

   initial begin
      repeat (5) @(posedge clk_sys);
      @(negedge clk_sys);
      check_eq("reset_key", {21'd0, ps2_key}, 0);
      check_eq("reset_err", {31'd0, frame_err}, 0);
      @(posedge clk_sys); #1;
      reset = 1'b0;
      repeat (10) @(posedge clk_sys);

      // plain make code, with pin-to-event latency
      exp_q.push_back(12'h21C);
      lat_armed = 1'b1;
      send_frame(8'h1C, 1'b0, 11);
      drain("drain_1c", 200);

      // extended break: one event only
      exp_q.push_back(12'h175);
      send_frame(8'hE0, 1'b0, 11);
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h75, 1'b0, 11);
      drain("drain_e0f075", 200);

      // E1 is transparent
      exp_q.push_back(12'h214);
      send_frame(8'hE1, 1'b0, 11);
      send_frame(8'h14, 1'b0, 11);
      drain("drain_e1", 200);

      // parity error then a clean retry
      exp_q.push_back(ERR_TOKEN);
      send_frame(8'h29, 1'b1, 11);
      drain("drain_par_err", 200);
      exp_q.push_back(12'h229);
      send_frame(8'h29, 1'b0, 11);
      drain("drain_29", 200);

      // truncated frame times out
      exp_q.push_back(ERR_TOKEN);
      send_frame(8'h16, 1'b0, 5);
      drain("drain_timeout", int'(TIMEOUT) + 200);
      exp_q.push_back(12'h216);
      send_frame(8'h16, 1'b0, 11);
      drain("drain_16", 200);

      // glitch shorter than the filter must not be sampled
      @(posedge clk_sys); #1;
      ps2_clk = 1'b0;
      repeat (FILTER_LEN - 1) @(posedge clk_sys);
      #1;
      ps2_clk = 1'b1;
      repeat (3 * FILTER_LEN) @(posedge clk_sys);
      @(negedge clk_sys);
      check_eq("glitch_bitcnt", {28'd0, dut.u_rx.bitcnt}, 0);
      exp_q.push_back(12'h25A);
      send_frame(8'h5A, 1'b0, 11);
      drain("drain_5a", 200);

      // reset mid-frame after a break prefix clears everything
      send_frame(8'hF0, 1'b0, 11);
      send_frame(8'h16, 1'b0, 3);
      @(posedge clk_sys); #1;
      reset = 1'b1;
      repeat (3) @(posedge clk_sys);
      @(negedge clk_sys);
      check_eq("midreset_key", {21'd0, ps2_key}, 0);
      check_eq("midreset_err", {31'd0, frame_err}, 0);
      @(posedge clk_sys); #1;
      reset = 1'b0;
      repeat (int'(TIMEOUT) + 100) @(posedge clk_sys);
      exp_q.push_back(12'h216);
      send_frame(8'h16, 1'b0, 11);
      drain("drain_after_reset", 200);
      @(negedge clk_sys);
      check_eq("toggle_after_reset", {31'd0, ps2_key[10]}, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
